alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one 64-bit ALU between two requesters (e.g. the address-generation path and the branch/CBZ path) in a multi-cycle variant of the datapath.
- Round-robin arbitration, valid/ready request handshake, registered operands, registered result.
- Single response channel tagged with requester id.
- One operation is in flight at a time.

Parameters:
WIDTH, 64, operand/result width; must equal the ALU data width.
CTLW, 4, ALU control code width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle (when valid)
req0_ctl  in  CTLW  ALU control code for requester 0
req0_a  in  WIDTH  operand A for requester 0
req0_b  in  WIDTH  operand B for requester 0
req1_valid, req1_ready, req1_ctl, req1_a, req1_b  (same as above, for requester 1)
resp_valid  out  1  result available
resp_ready  in  1  consumer takes result
resp_id  out  1  requester that issued the result
resp_data  out  WIDTH  ALU result
resp_zero  out  1  ALU Zero flag (resp_data == 0)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset:
  - state=IDLE, rr_last=1, so requester 0 has priority first.
  - resp_valid=0, resp_id=0, resp_data=0, resp_zero=0.
  - req0_ready=0, req1_ready=0 during the reset cycle.
  - Operand registers cleared to 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational. It goes high for at most one requester, and only in IDLE.
  - Grant rule: if only one requester is valid, grant it. If both are valid, grant the one not equal to rr_last.
  - On grant:
    - Latch ctl/a/b and grant id into registers.
    - rr_last <= grant id.
    - Go to EXEC.
  - No valid requester: stay in IDLE.
  - rr_last does not change without a grant.
- EXEC (exactly one cycle):
  - The ALU sees the registered ctl/a/b.
  - At the clock edge, capture the ALU result into resp_data, the Zero flag into resp_zero, and the id into resp_id.
  - Set resp_valid <= 1 and go to RESP.
- RESP:
  - resp_valid=1. resp_data, resp_zero and resp_id hold stable until resp_ready=1.
  - On resp_ready=1: resp_valid <= 0 and go to IDLE.
  - No new grant in the same cycle, so ready is low throughout RESP.
- Latency: handshake edge T, result visible with resp_valid at T+2. Back-to-back throughput is one op per 3 cycles when resp_ready is tied high.
- ALU function, by ctl value:
  - 0: A&B
  - 1: A|B
  - 2: A+B, modulo 2^WIDTH, carry discarded
  - 6: A−B, modulo 2^WIDTH
  - 7: result = (B==0) ? 0 : 1
  - any other code: result 0 with resp_zero=1. This is not an error; no flag is raised.
- Operands and ctl are sampled only on the handshake edge. Later changes on req inputs do not affect the in-flight op.
- A requester that holds valid while not granted must keep ctl/a/b stable. The arbiter does not check this.
- Reset asserted in EXEC or RESP: the in-flight op is dropped, resp_valid=0 on the next cycle, and no response is ever produced for it.
- Simultaneous valid on both requesters for consecutive ops: grants strictly alternate 0,1,0,1…
- A continuously valid single requester is granted on every IDLE visit.

Decomposition:
- Shared package alu_pkg:
  - CTLW, WIDTH defaults.
  - Localparams ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_CBZ=7.
  - FSM state encoding (IDLE=0, EXEC=1, RESP=2).
- Sub-module: instantiate the existing ALU module (ports ALUctl, A, B, ALUOut, Zero) fed from the operand registers. Do not reimplement the arithmetic.
- Arbiter grant logic stays inline, roughly 15 lines.

Test Plan:
- Reset, then idle: resp_valid=0 and both readys=0 during reset. After reset, req0_ready=0 with no valids.
- Single op: req0 ADD a=5, b=7 at edge T → req0_ready=1 at T; resp_valid=1 at T+2 with data=12, zero=0, id=0; resp_ready=1 returns FSM to IDLE next cycle.
- Contention: both valid, req0 SUB a=9, b=9 and req1 OR a=0xF0, b=0x0F, resp_ready tied 1 → first grant id0 (data=0, zero=1), next grant id1 (data=0xFF, zero=0). Continued both-valid alternates ids.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP with req1 valid → resp fields stable, req1_ready stays 0. Raise resp_ready → req1 granted on the following IDLE cycle.
- Edge codes: ctl 7 with b=0 → data=0, zero=1; ctl 7 with b=3 → data=1. ctl 4 → data=0, zero=1. ADD 0xFFFF_FFFF_FFFF_FFFF+1 → data=0, zero=1.
- Reset mid-op: assert reset during EXEC → no response appears. After release, a req1 op is granted first only if req0 is not valid, since rr_last=1 gives req0 priority.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, control codes and the arbiter FSM states.
package alu_pkg;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned CTLW  = 4;

  localparam logic [CTLW-1:0] ALU_AND = 4'd0;
  localparam logic [CTLW-1:0] ALU_OR  = 4'd1;
  localparam logic [CTLW-1:0] ALU_ADD = 4'd2;
  localparam logic [CTLW-1:0] ALU_SUB = 4'd6;
  localparam logic [CTLW-1:0] ALU_CBZ = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 64-bit ALU with Zero flag; unknown control codes yield 0.
module alu_share_arbiter_alu #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CTLW  = 4
) (
  input  logic [CTLW-1:0]  ALUctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero
);
  import alu_pkg::*;

  always_comb begin
    ALUOut = '0;
    case (ALUctl)
      ALU_AND: ALUOut = A & B;
      ALU_OR:  ALUOut = A | B;
      ALU_ADD: ALUOut = A + B;
      ALU_SUB: ALUOut = A - B;
      // CBZ reports "B is non-zero" as 1 so Zero asserts exactly when B == 0
      ALU_CBZ: ALUOut = (B == '0) ? '0 : WIDTH'(1);
      default: ALUOut = '0;
    endcase
  end

  assign Zero = (ALUOut == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters; one op in flight,
// registered operands and a registered, id-tagged response.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CTLW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [CTLW-1:0]  req0_ctl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [CTLW-1:0]  req1_ctl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero
);
  import alu_pkg::*;

  state_t             r_state, w_state_nxt;
  logic               r_rr_last;
  logic [CTLW-1:0]    r_ctl;
  logic [WIDTH-1:0]   r_a, r_b;
  logic               r_id;
  logic               r_resp_valid, r_resp_id, r_resp_zero;
  logic [WIDTH-1:0]   r_resp_data;
  logic               w_gnt, w_gnt_id;
  logic [WIDTH-1:0]   w_alu_out;
  logic               w_alu_zero;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 1'b0;
    w_gnt_id    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          w_gnt       = 1'b1;
          // On contention the requester not served last wins
          w_gnt_id    = (req0_valid && req1_valid) ? ~r_rr_last : req1_valid;
          w_state_nxt = EXEC;
        end
      end
      EXEC:    w_state_nxt = RESP;
      RESP:    if (resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign req0_ready = w_gnt && !w_gnt_id && !reset;
  assign req1_ready = w_gnt &&  w_gnt_id && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_last    <= 1'b1;
      r_ctl        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_data  <= '0;
      r_resp_zero  <= 1'b0;
    end else begin
      if (w_gnt) begin
        r_rr_last <= w_gnt_id;
        r_id      <= w_gnt_id;
        r_ctl     <= w_gnt_id ? req1_ctl : req0_ctl;
        r_a       <= w_gnt_id ? req1_a   : req0_a;
        r_b       <= w_gnt_id ? req1_b   : req0_b;
      end
      if (r_state == EXEC) begin
        r_resp_valid <= 1'b1;
        r_resp_id    <= r_id;
        r_resp_data  <= w_alu_out;
        r_resp_zero  <= w_alu_zero;
      end
      if ((r_state == RESP) && resp_ready) r_resp_valid <= 1'b0;
    end
  end

  alu_share_arbiter_alu #(
    .WIDTH(WIDTH),
    .CTLW (CTLW)
  ) u_alu (
    .ALUctl(r_ctl),
    .A     (r_a),
    .B     (r_b),
    .ALUOut(w_alu_out),
    .Zero  (w_alu_zero)
  );

  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign resp_zero  = r_resp_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: issue side predicts grants and results,
// a separate monitor pops and compares every presented response.
module tb_alu_share_arbiter;

  logic        clk, reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_ctl, req1_ctl;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id, resp_zero;
  logic [63:0] resp_data;

  alu_share_arbiter #(.WIDTH(64), .CTLW(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_zero(resp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        id;
    logic [63:0] data;
    logic        zero;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  // Issue-side view of the arbiter: busy from grant until the response is taken
  bit m_busy, m_last, m_prev_consume, m_rst_prev;
  bit hs0, hs1;

  function automatic logic [63:0] ref_alu(logic [3:0] c, logic [63:0] a, logic [63:0] b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return (b != 64'd0) ? 64'd1 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic cycle();
    int   g;
    exp_t e;
    @(negedge clk);
    hs0 = 0;
    hs1 = 0;
    g   = -1;
    if (m_prev_consume) m_busy = 0;
    if (m_rst_prev) begin
      chk("post_reset_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("post_reset_resp_data", resp_data, 64'd0);
    end
    if (reset) begin
      m_busy = 0;
      m_last = 1;
      sbq.delete();
      chk("reset_req0_ready", {63'd0, req0_ready}, 64'd0);
      chk("reset_req1_ready", {63'd0, req1_ready}, 64'd0);
    end else begin
      if (!m_busy) begin
        if (req0_valid && req1_valid) g = m_last ? 0 : 1;
        else if (req0_valid)          g = 0;
        else if (req1_valid)          g = 1;
      end
      chk("req0_ready", {63'd0, req0_ready}, {63'd0, g == 0});
      chk("req1_ready", {63'd0, req1_ready}, {63'd0, g == 1});
      if (g >= 0) begin
        e.id   = (g == 1);
        e.data = (g == 1) ? ref_alu(req1_ctl, req1_a, req1_b) : ref_alu(req0_ctl, req0_a, req0_b);
        e.zero = (e.data == 64'd0);
        e.due  = cyc + 2;
        sbq.push_back(e);
        m_busy = 1;
        m_last = (g == 1);
        hs0    = (g == 0);
        hs1    = (g == 1);
      end
    end
    m_prev_consume = resp_valid && resp_ready && !reset;
    m_rst_prev     = reset;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(int n);
    for (int i = 0; i < 8; i++) begin
      cycle();
      if ((n == 0 && hs0) || (n == 1 && hs1)) return;
    end
    checks++;
    errors++;
    $display("FAIL grant_timeout: requester %0d got no grant within 8 cycles", n);
  endtask

  task automatic set_req(int n, bit v, logic [3:0] c, logic [63:0] a, logic [63:0] b);
    if (n == 0) begin
      req0_valid = v; req0_ctl = c; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_ctl = c; req1_a = a; req1_b = b;
    end
  endtask

  function automatic logic [3:0] rand_ctl();
    case ($urandom_range(0, 7))
      0:       return 4'd0;
      1:       return 4'd1;
      2:       return 4'd2;
      3:       return 4'd6;
      4:       return 4'd7;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  function automatic logic [63:0] rand_opnd();
    if ($urandom_range(0, 3) == 0) return 64'($urandom_range(0, 3));
    return {$urandom, $urandom};
  endfunction

  // Response monitor: a response is popped when first presented and rechecked while held
  initial begin
    exp_t cur;
    bit   have;
    have = 0;
    forever begin
      @(negedge clk);
      if (reset) have = 0;
      else if (resp_valid) begin
        if (!have) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: id %0d data 0x%0h with nothing outstanding", resp_id, resp_data);
          end else begin
            cur  = sbq.pop_front();
            have = 1;
            chk("resp_latency", 64'(cyc), 64'(cur.due));
          end
        end
        if (have) begin
          chk("resp_id", {63'd0, resp_id}, {63'd0, cur.id});
          chk("resp_data", resp_data, cur.data);
          chk("resp_zero", {63'd0, resp_zero}, {63'd0, cur.zero});
          if (resp_ready) have = 0;
        end
      end
    end
  end

  initial begin
    logic [3:0]  ectl [4] = '{4'd7, 4'd7, 4'd4, 4'd2};
    logic [63:0] ea   [4] = '{64'd5, 64'd5, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] eb   [4] = '{64'd0, 64'd3, 64'd9, 64'd1};

    reset = 1; resp_ready = 0;
    set_req(0, 0, 4'd0, 64'd0, 64'd0);
    set_req(1, 0, 4'd0, 64'd0, 64'd0);
    m_last = 1; m_busy = 0; m_prev_consume = 0; m_rst_prev = 0;
    cycle();
    cycle();
    reset = 0;
    repeat (2) cycle();

    // Contention straight after reset: requester 0 first, then strict alternation
    resp_ready = 1;
    set_req(0, 1, 4'd6, 64'd9, 64'd9);
    set_req(1, 1, 4'd1, 64'hF0, 64'h0F);
    repeat (18) cycle();
    set_req(0, 0, 4'd0, 64'd0, 64'd0);
    set_req(1, 0, 4'd0, 64'd0, 64'd0);
    repeat (3) cycle();

    // Single op
    set_req(0, 1, 4'd2, 64'd5, 64'd7);
    wait_hs(0);
    req0_valid = 0;
    repeat (3) cycle();

    // Backpressure with a waiting requester
    resp_ready = 0;
    set_req(0, 1, 4'd0, 64'hFF00, 64'h0FF0);
    wait_hs(0);
    req0_valid = 0;
    set_req(1, 1, 4'd1, 64'h33, 64'h0C);
    repeat (7) cycle();
    resp_ready = 1;
    wait_hs(1);
    req1_valid = 0;
    repeat (3) cycle();

    // Edge control codes and wraparound
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, ectl[i], ea[i], eb[i]);
      wait_hs(0);
      req0_valid = 0;
      repeat (2) cycle();
    end

    // Reset while the op is executing: the op must vanish
    set_req(0, 1, 4'd2, 64'd1, 64'd2);
    wait_hs(0);
    req0_valid = 0;
    reset = 1;
    cycle();
    reset = 0;
    repeat (4) cycle();
    set_req(0, 1, 4'd0, 64'hAA, 64'h0F);
    set_req(1, 1, 4'd2, 64'd40, 64'd2);
    wait_hs(0);
    req0_valid = 0;
    wait_hs(1);
    req1_valid = 0;
    repeat (3) cycle();

    // Random traffic; a waiting requester holds its operands
    for (int i = 0; i < 600; i++) begin
      if (!req0_valid || hs0)
        set_req(0, $urandom_range(0, 99) < 60, rand_ctl(), rand_opnd(), rand_opnd());
      if (!req1_valid || hs1)
        set_req(1, $urandom_range(0, 99) < 60, rand_ctl(), rand_opnd(), rand_opnd());
      resp_ready = $urandom_range(0, 99) < 70;
      cycle();
    end

    req0_valid = 0;
    req1_valid = 0;
    resp_ready = 1;
    repeat (6) cycle();
    chk("drain_queue_empty", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
